// File: rtl/if_prefetch.sv
// Instruction-fetch stage: assembles 32-bit words from narrow memctrl beats and
// buffers them with their PCs in a small prefetch queue feeding IF/ID.
module if_prefetch #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          MEM_BYTES   = 1,
    parameter int          QUEUE_DEPTH = 4,
    parameter int          STALL_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_WIDTH-1:0]   stall,
    input  logic                     branch_flag_i,
    input  logic [31:0]              branch_target_i,
    output logic                     r_to_memctrl,
    output logic [31:0]              addr_to_memctrl,
    input  logic                     r_from_memctrl,
    input  logic [8*MEM_BYTES-1:0]   data_from_memctrl,
    output logic [31:0]              pc_o,
    output logic [31:0]              inst_o,
    output logic                     flag_o,
    output logic                     stallreq_o
);
    localparam int BEATS = 4 / MEM_BYTES;
    localparam int BW    = 8 * MEM_BYTES;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0]       LAST_BEAT = 2'(BEATS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         beat_reg, beat_next;
    logic [31:0]        fetch_pc_reg, fetch_pc_next;
    logic [31:0]        addr_reg, addr_next;
    logic [31:0]        asm_reg, asm_next;
    logic               discard_reg, discard_next;
    logic [31:0]        asm_merged;
    logic [31:0]        target;

    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg, count_after;
    logic [31:0]        pc_q   [QUEUE_DEPTH];
    logic [31:0]        inst_q [QUEUE_DEPTH];
    logic               push, pop, beat_done, last_beat;
    logic               unused_bits;

    assign unused_bits     = ^{stall, branch_target_i[1:0]};
    assign target          = {branch_target_i[31:2], 2'b00};
    assign r_to_memctrl    = (state_reg == REQ);
    assign addr_to_memctrl = addr_reg;

    // Incoming beat lands in its own byte lane; other lanes keep earlier beats.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign asm_merged[gi*BW +: BW] = (beat_reg == 2'(gi)) ? data_from_memctrl
                                                              : asm_reg[gi*BW +: BW];
    end

    assign beat_done   = (state_reg == REQ) && r_from_memctrl;
    assign last_beat   = (beat_reg == LAST_BEAT);
    assign push        = beat_done && last_beat && !discard_reg && !branch_flag_i;
    assign pop         = (count_reg != '0) && !stall[0] && !branch_flag_i;
    assign count_after = count_reg + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    always_comb begin
        state_next    = state_reg;
        beat_next     = beat_reg;
        fetch_pc_next = fetch_pc_reg;
        addr_next     = addr_reg;
        asm_next      = asm_reg;
        discard_next  = discard_reg;
        case (state_reg)
            IDLE: begin
                if (count_reg < DEPTH_C) state_next = REQ;
            end
            REQ: begin
                if (beat_done) begin
                    asm_next = asm_merged;
                    if (discard_reg) begin
                        // Stale beat from a flushed fetch: restart at beat 0 of the new PC.
                        beat_next    = 2'd0;
                        addr_next    = fetch_pc_reg;
                        discard_next = 1'b0;
                    end else if (!last_beat) begin
                        beat_next = beat_reg + 2'd1;
                        addr_next = addr_reg + 32'(MEM_BYTES);
                    end else begin
                        beat_next     = 2'd0;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                        addr_next     = fetch_pc_reg + 32'd4;
                        if (count_after >= DEPTH_C) state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (branch_flag_i) begin
            fetch_pc_next = target;
            beat_next     = 2'd0;
            if (state_reg == REQ && !r_from_memctrl) begin
                // Memctrl is never abandoned: finish the old beat, then drop it.
                discard_next = 1'b1;
                addr_next    = addr_reg;
            end else begin
                discard_next = 1'b0;
                addr_next    = target;
                state_next   = REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_reg     <= 2'd0;
            fetch_pc_reg <= RESET_PC;
            addr_reg     <= RESET_PC;
            asm_reg      <= '0;
            discard_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_reg     <= beat_next;
            fetch_pc_reg <= fetch_pc_next;
            addr_reg     <= addr_next;
            asm_reg      <= asm_next;
            discard_reg  <= discard_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_reg]   <= fetch_pc_reg;
            inst_q[tail_reg] <= asm_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            pc_o       <= '0;
            inst_o     <= '0;
            flag_o     <= 1'b0;
            stallreq_o <= 1'b1;
        end else begin
            if (branch_flag_i) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) tail_reg <= tail_reg + 1'b1;
                if (pop)  head_reg <= head_reg + 1'b1;
                count_reg <= count_after;
            end
            flag_o     <= pop;
            stallreq_o <= (count_reg == '0);
            if (pop) begin
                pc_o   <= pc_q[head_reg];
                inst_o <= inst_q[head_reg];
            end
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: three instances (1, 2 and 4 byte beats) share control
// inputs; each has its own memctrl responder and an in-order stream scoreboard.
module tb_if_prefetch;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        branch = 1'b0;
    logic [31:0] target = '0;
    int          dly_mode = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        r_to_a [3];
    logic        rf_a [3];
    logic        flag_a [3];
    logic        stallreq_a [3];
    logic [31:0] addr_a [3];
    logic [31:0] pc_a [3];
    logic [31:0] inst_a [3];
    int          n_emit [3] = '{0, 0, 0};
    typedef logic [31:0] addr_q_t [$];
    addr_q_t     beat_log [3];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a == 32'd0) return 8'h13;
        if (a < 32'd4) return 8'h00;
        return 8'(a ^ (a >> 7) ^ 32'h5a);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {mem_byte(pc + 3), mem_byte(pc + 2), mem_byte(pc + 1), mem_byte(pc)};
    endfunction

    function automatic logic [31:0] log_at(input int i, input int j);
        if (j < beat_log[i].size()) return beat_log[i][j];
        return 32'hdeadbeef;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int MB = 1 << gi;
        logic            rf = 1'b0;
        logic [8*MB-1:0] data = '0;
        logic [31:0]     exp_pc = 32'h0;
        int              cnt = 0;
        int              dly = 0;

        assign rf_a[gi] = rf;

        if_prefetch #(
            .RESET_PC(32'h0), .MEM_BYTES(MB), .QUEUE_DEPTH(QD), .STALL_WIDTH(6)
        ) dut (
            .clk(clk), .rst(rst), .stall(stall),
            .branch_flag_i(branch), .branch_target_i(target),
            .r_to_memctrl(r_to_a[gi]), .addr_to_memctrl(addr_a[gi]),
            .r_from_memctrl(rf), .data_from_memctrl(data),
            .pc_o(pc_a[gi]), .inst_o(inst_a[gi]), .flag_o(flag_a[gi]),
            .stallreq_o(stallreq_a[gi])
        );

        // Memctrl model: answers each request after dly extra idle cycles.
        always @(posedge clk) begin
            #1;
            if (rst || !r_to_a[gi]) begin
                rf  = 1'b0;
                cnt = 0;
                dly = (dly_mode < 0) ? int'($urandom_range(0, 2)) : dly_mode;
            end else if (cnt >= dly) begin
                rf = 1'b1;
                for (int k = 0; k < MB; k++) data[8*k +: 8] = mem_byte(addr_a[gi] + 32'(k));
                cnt = 0;
                dly = (dly_mode < 0) ? int'($urandom_range(0, 2)) : dly_mode;
            end else begin
                rf = 1'b0;
                cnt++;
            end
        end

        // Emitted stream must be contiguous PCs, restarting at the target after a flush.
        always @(posedge clk) begin
            logic        rs, b, s, bt;
            logic [31:0] t, a;
            rs = rst; b = branch; t = target; s = stall[0];
            bt = r_to_a[gi] & rf; a = addr_a[gi];
            #1;
            if (rs) begin
                beat_log[gi].delete();
                exp_pc = 32'h0;
            end else begin
                if (bt) beat_log[gi].push_back(a);
                if (b) begin
                    chk("flush_flag", 32'(flag_a[gi]), 0);
                    exp_pc = {t[31:2], 2'b00};
                end else if (flag_a[gi]) begin
                    chk("pop_while_stalled", 32'(s), 0);
                    chk("stream_pc", pc_a[gi], exp_pc);
                    chk("stream_inst", inst_a[gi], mem_word(exp_pc));
                    exp_pc += 32'd4;
                    n_emit[gi]++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input int i);
        chk("rst_r_to", 32'(r_to_a[i]), 0);
        chk("rst_addr", addr_a[i], 0);
        chk("rst_pc", pc_a[i], 0);
        chk("rst_inst", inst_a[i], 0);
        chk("rst_flag", 32'(flag_a[i]), 0);
        chk("rst_stallreq", 32'(stallreq_a[i]), 1);
    endtask

    task automatic wait_flag(input int i, input string tag);
        int n = 0;
        while (!flag_a[i] && n < 80) begin tick(1); n++; end
        chk(tag, 32'(flag_a[i]), 1);
    endtask

    task automatic wait_log(input int i, input int sz, input string tag);
        int n = 0;
        while (beat_log[i].size() < sz && n < 80) begin tick(1); n++; end
        chk(tag, 32'(beat_log[i].size() >= sz), 1);
    endtask

    initial begin
        logic found;
        logic prev_sr;
        int   s;

        // Reset values and first fetch (1-byte beats, 1-cycle response).
        dly_mode = 0; rst = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) chk_reset(i);
        rst = 1'b0;
        found = 1'b0; prev_sr = 1'b1;
        for (int k = 1; k <= 30 && !found; k++) begin
            tick(1);
            if (k == 1) begin
                chk("first_req", 32'(r_to_a[0]), 1);
                chk("first_addr", addr_a[0], 0);
            end
            if (flag_a[0]) begin
                found = 1'b1;
                chk("first_latency", k, 6);
                chk("first_pc", pc_a[0], 0);
                chk("first_inst", inst_a[0], 32'h00000013);
                chk("stallreq_drop", 32'(stallreq_a[0]), 0);
                chk("stallreq_before", 32'(prev_sr), 1);
            end
            prev_sr = stallreq_a[0];
        end
        chk("first_found", 32'(found), 1);
        for (int j = 0; j < 4; j++) chk("first_beats", log_at(0, j), j);

        // Stall held: 4-byte instance fills the queue and parks in IDLE.
        stall[0] = 1'b1; rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(40);
        chk("full_fetches", beat_log[2].size(), QD);
        for (int j = 0; j < QD; j++) chk("full_pc", log_at(2, j), 4 * j);
        chk("full_idle", 32'(r_to_a[2]), 0);
        chk("full_stallreq", 32'(stallreq_a[2]), 0);
        stall[0] = 1'b0;
        for (int j = 0; j < QD; j++) begin
            tick(1);
            chk("drain_flag", 32'(flag_a[2]), 1);
            chk("drain_pc", pc_a[2], 4 * j);
        end
        wait_log(2, QD + 1, "resume_wait");
        chk("resume_addr", log_at(2, QD), 16);

        // Flush while beat 0 of PC 8 is outstanding (2-byte instance).
        dly_mode = 2; rst = 1'b1;
        tick(1);
        rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick(1);
            if (r_to_a[1] && addr_a[1] == 32'd8 && !rf_a[1]) found = 1'b1;
        end
        chk("pc8_seen", 32'(found), 1);
        s = beat_log[1].size();
        branch = 1'b1; target = 32'h103;
        tick(1);
        branch = 1'b0;
        wait_log(1, s + 2, "discard_wait");
        chk("discard_old_addr", log_at(1, s), 32'd8);
        chk("discard_new_addr", log_at(1, s + 1), 32'h100);
        wait_flag(1, "target_flag");
        chk("target_pc", pc_a[1], 32'h100);

        // Flush coinciding with a last-beat push and a pending pop.
        dly_mode = 1; stall[0] = 1'b1; rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(12);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (r_to_a[0] && rf_a[0] && addr_a[0][1:0] == 2'd3) found = 1'b1;
            else tick(1);
        end
        chk("lastbeat_seen", 32'(found), 1);
        chk("queue_nonempty", 32'(stallreq_a[0]), 0);
        branch = 1'b1; target = 32'h200; stall[0] = 1'b0;
        tick(1);
        branch = 1'b0;
        chk("coincide_flag", 32'(flag_a[0]), 0);
        tick(1);
        chk("coincide_empty", 32'(stallreq_a[0]), 1);
        wait_flag(0, "coincide_wait");
        chk("coincide_pc", pc_a[0], 32'h200);
        chk("coincide_inst", inst_a[0], mem_word(32'h200));

        // One-cycle reset while a beat is outstanding.
        dly_mode = 2;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick(1);
            if (r_to_a[0] && !rf_a[0] && addr_a[0] > 32'h200) found = 1'b1;
        end
        chk("midbeat_seen", 32'(found), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) chk_reset(i);
        wait_flag(0, "restart_wait");
        chk("restart_pc", pc_a[0], 32'h0);
        chk("restart_beat0", log_at(0, 0), 32'h0);

        // Randomized stall, flush and memory latency.
        dly_mode = -1; rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) n_emit[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            stall  = 6'($urandom);
            stall[0] = ($urandom_range(0, 99) < 30);
            branch = ($urandom_range(0, 99) < 3);
            target = 32'($urandom_range(0, 4095));
            tick(1);
        end
        branch = 1'b0; stall = '0;
        tick(60);
        for (int i = 0; i < 3; i++) chk("random_progress", 32'(n_emit[i] > 50), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
